rx_slicer_ref_track: RTL and testbench
======================================

Name: rx_slicer_ref_track

Overview:
- Receive-side stage directly downstream of the channel model.
- Runs at the sample rate. Picks one sample per symbol at a fixed phase, then slices it to a Gray-coded 4-ASK decision.
- Tracks the decision reference level from a block mean of |x|.
- Reports mean squared slicer error per block; this feeds the MER/BER bench logic.

Parameters:
- SAMPLE_PHASE, 0, sample index within the symbol (0..3) that is sliced; phase 0 is the sample coincident with sym_clk_ena.
- LOG2_N, 8, log2 of block length N in symbols for the reference/error averaging.
- INIT_REF, 32768, reset/initial reference level (1s17); equals 2a for ASK levels ±a, ±3a.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sam_clk_ena  in  1  sample strobe, one clk wide, 4 per symbol
- sym_clk_ena  in  1  symbol strobe; valid only coincident with sam_clk_ena
- sig_in  in  18  signed 1s17 channel output sample
- sym_out  out  2  Gray decision: 00=-3a, 01=-a, 11=+a, 10=+3a
- sym_valid  out  1  one-clk pulse, sym_out/slicer_out/err_out valid
- slicer_out  out  18  signed ideal level of the decision
- err_out  out  18  signed sig - slicer_out, saturated
- ref_level  out  18  signed current reference (2a estimate)
- err_pow  out  36  unsigned block mean of err_out^2
- block_valid  out  1  one-clk pulse when ref_level/err_pow update

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: all outputs 0 except ref_level=INIT_REF.
  - Internal state: phase counter, symbol counter and accumulators cleared.
  - Release: operation restarts at block start.
- Phase counter (2 bit):
  - Advances only on sam_clk_ena.
  - cur_phase = 0 if sym_clk_ena else phase.
  - Next phase = cur_phase+1.
  - sym_clk_ena without sam_clk_ena is ignored.
- Capture: on sam_clk_ena && cur_phase==SAMPLE_PHASE, register sig_in into stage-1 (x).
- Stage 2 (one clk after capture):
  - Decisions use R=ref_level.
  - x >= R: sym 10, level R+(R>>>1).
  - 0 <= x < R: sym 11, level R>>>1.
  - -R < x < 0: sym 01, level -(R>>>1).
  - x <= -R: sym 00, level -(R+(R>>>1)).
  - err_out = x - level, computed 19 bit, saturated to [-131072, 131071].
- Latency: sym_valid asserts exactly 2 clk after the capture cycle and holds for one clk.
- Data outputs: sym_out, slicer_out and err_out hold their value until the next sym_valid.
- Accumulation on each sym_valid:
  - abs_acc += |x|, with |-131072| clamped to 131071; width 17+LOG2_N.
  - err_acc += err_out^2; each term is 35 bit unsigned; width 35+LOG2_N.
  - sym_cnt (LOG2_N bits) increments.
- Block end (the sym_valid where sym_cnt==N-1), on the next clk:
  - ref_level = (abs_acc incl. this symbol) >> LOG2_N, clamped to a minimum of 1.
  - err_pow = (err_acc incl. this symbol) >> LOG2_N.
  - block_valid pulses.
  - Accumulators and sym_cnt clear; sym_cnt wraps to 0.
- New reference: applies to the first symbol sliced after block_valid. The symbol in flight during the update uses the old R.
- No back-pressure: the consumer must accept every sym_valid.

Test Plan:
- Reset: assert reset_n=0 mid-stream -> outputs immediately 0, ref_level=32768. After release, sym_cnt restarts at 0.
- Ideal symbol: sam_clk_ena every 4 clk, sym_clk_ena every 16 clk, sig_in=49152 at phase 0 -> sym_valid 2 clk after capture, sym_out=10, slicer_out=49152, err_out=0.
- Thresholds with R=32768:
  - 32768 -> 10 (err -16384)
  - 32767 -> 11 (err 16383)
  - 0 -> 11 (err -16384)
  - -1 -> 01 (err 16383)
  - -32768 -> 00 (err 16384)
  - -131072 -> 00 (err -81920)
- Phase selection: SAMPLE_PHASE=2, sig_in ramps per sample, plus stray sym_clk_ena pulses without sam_clk_ena -> only the third sample of each symbol is sliced and strays have no effect.
- Block update: 256 symbols cycling ±20000, ±60000 equally -> block_valid once; ref_level=40000, err_pow=65377280 (errors ±3616/±10848 vs old R). The next block of the same data -> err_pow=0.
- Reset mid-block: 100 symbols, pulse reset_n low -> ref_level back to 32768. block_valid occurs only after 256 further symbols.

Source files
------------

// File: rtl/rx_slicer_ref_track_if.sv
// rx_slicer_ref_track_if: sample stream in, symbol decisions and block statistics out
interface rx_slicer_ref_track_if;
  logic sam_clk_ena;
  logic sym_clk_ena;
  logic signed [17:0] sig_in;
  logic [1:0] sym_out;
  logic sym_valid;
  logic signed [17:0] slicer_out;
  logic signed [17:0] err_out;
  logic signed [17:0] ref_level;
  logic [35:0] err_pow;
  logic block_valid;
  modport master (
    output sam_clk_ena, sym_clk_ena, sig_in,
    input sym_out, sym_valid, slicer_out, err_out, ref_level, err_pow, block_valid
  );
  modport slave (
    input sam_clk_ena, sym_clk_ena, sig_in,
    output sym_out, sym_valid, slicer_out, err_out, ref_level, err_pow, block_valid
  );
endinterface

// File: rtl/rx_slicer_ref_track.sv
// rx_slicer_ref_track: 4-ASK slicer with block-mean reference tracking and mean squared error
module rx_slicer_ref_track #(
  parameter int SAMPLE_PHASE = 0,
  parameter int LOG2_N = 8,
  parameter int INIT_REF = 32768
) (
  input logic clk,
  input logic reset_n,
  rx_slicer_ref_track_if.slave bus
);
  localparam int ABW = 17 + LOG2_N;
  localparam int EBW = 35 + LOG2_N;
  localparam logic [1:0] SP = 2'(SAMPLE_PHASE);
  logic [1:0] phase, cur_phase;
  logic capture, cap_v;
  logic signed [17:0] x;
  logic signed [18:0] x19, r19, half19, full19, lvl19;
  logic signed [19:0] diff20;
  logic ge_r, gt_nr;
  logic [1:0] sym_d;
  logic signed [17:0] lvl_d, err_d;
  logic [16:0] abs_d, abs_r, mean_abs;
  logic [34:0] err_sq;
  logic [LOG2_N-1:0] sym_cnt;
  logic [ABW-1:0] abs_acc, abs_sum;
  logic [EBW-1:0] err_acc, err_sum;
  // slicing, saturation and block statistics datapath
  always_comb begin
    cur_phase = bus.sym_clk_ena ? 2'd0 : phase;
    capture = bus.sam_clk_ena && (cur_phase == SP);
    x19 = x;
    r19 = bus.ref_level;
    half19 = r19 >>> 1;
    full19 = r19 + half19;
    ge_r = x >= bus.ref_level;
    gt_nr = x19 > -r19;
    sym_d = ge_r ? 2'b10 : !x[17] ? 2'b11 : gt_nr ? 2'b01 : 2'b00;
    lvl19 = ge_r ? full19 : !x[17] ? half19 : gt_nr ? -half19 : -full19;
    diff20 = 20'(x19) - 20'(lvl19);
    err_d = (diff20 > 20'sh1ffff) ? 18'sh1ffff : (diff20 < 20'she0000) ? 18'sh20000 : diff20[17:0];
    lvl_d = (lvl19 > 19'sh1ffff) ? 18'sh1ffff : (lvl19 < 19'sh60000) ? 18'sh20000 : lvl19[17:0];
    abs_d = !x[17] ? x[16:0] : (x == 18'sh20000) ? 17'h1ffff : 17'(-x);
    err_sq = 35'(36'(bus.err_out) * 36'(bus.err_out));
    abs_sum = abs_acc + ABW'(abs_r);
    err_sum = err_acc + EBW'(err_sq);
    mean_abs = 17'(abs_sum >> LOG2_N);
  end
  // phase tracking and capture of the selected sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase <= '0;
      cap_v <= 1'b0;
      x <= '0;
    end else begin
      cap_v <= capture;
      if (bus.sam_clk_ena) phase <= cur_phase + 2'd1;
      if (capture) x <= bus.sig_in;
    end
  end
  // registered decision, ideal level and error for the captured sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.sym_valid <= 1'b0;
      bus.sym_out <= '0;
      bus.slicer_out <= '0;
      bus.err_out <= '0;
      abs_r <= '0;
    end else begin
      bus.sym_valid <= cap_v;
      if (cap_v) begin
        bus.sym_out <= sym_d;
        bus.slicer_out <= lvl_d;
        bus.err_out <= err_d;
        abs_r <= abs_d;
      end
    end
  end
  // block accumulation; reference and error power refresh after the last symbol of a block
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ref_level <= 18'(INIT_REF);
      bus.err_pow <= '0;
      bus.block_valid <= 1'b0;
      abs_acc <= '0;
      err_acc <= '0;
      sym_cnt <= '0;
    end else begin
      bus.block_valid <= 1'b0;
      if (bus.sym_valid) begin
        if (sym_cnt == '1) begin
          bus.ref_level <= (mean_abs == 17'd0) ? 18'sd1 : 18'(mean_abs);
          bus.err_pow <= 36'(err_sum >> LOG2_N);
          bus.block_valid <= 1'b1;
          abs_acc <= '0;
          err_acc <= '0;
          sym_cnt <= '0;
        end else begin
          abs_acc <= abs_sum;
          err_acc <= err_sum;
          sym_cnt <= sym_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rx_slicer_ref_track.sv
// tb_rx_slicer_ref_track: directed stimulus against a symbol-level reference model
module tb_rx_slicer_ref_track;
  logic clk = 1'b0;
  logic reset_n;
  logic sam, sym;
  logic signed [17:0] sig;
  int vectors = 0, miscompares = 0, bv_cnt = 0, b0;
  bit chk_en = 1'b0;
  logic [2:0] svh;
  rx_slicer_ref_track_if if0 ();
  rx_slicer_ref_track_if if1 ();
  assign if0.sam_clk_ena = sam;
  assign if0.sym_clk_ena = sym;
  assign if0.sig_in = sig;
  assign if1.sam_clk_ena = sam;
  assign if1.sym_clk_ena = sym;
  assign if1.sig_in = sig;
  rx_slicer_ref_track #(.SAMPLE_PHASE(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  rx_slicer_ref_track #(.SAMPLE_PHASE(2)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  always #5 clk = ~clk;

  // model state per instance (0: phase 0, 1: phase 2)
  int ph[2], cnt[2];
  bit pend[2], e_sv[2], e_bv[2];
  logic [1:0] e_sym[2];
  longint px[2], rr[2], sa[2], se[2], e_slc[2], e_err[2], e_x[2], e_pow[2];
  longint tx[6] = '{32768, 32767, 0, -1, -32768, -131072};
  int ts[6] = '{2, 3, 3, 1, 0, 0};
  longint te[6] = '{-16384, 16383, -16384, 16383, 16384, -81920};
  longint pat[4] = '{20000, 60000, -20000, -60000};

  function automatic longint clamp18(input longint v);
    return v > 131071 ? 131071 : v < -131072 ? -131072 : v;
  endfunction

  task automatic slice(input longint xv, input longint r, output logic [1:0] s, output longint l, output longint e);
    longint h = r / 2;
    if (xv >= r) begin s = 2'b10; l = r + h; end
    else if (xv >= 0) begin s = 2'b11; l = h; end
    else if (xv > -r) begin s = 2'b01; l = -h; end
    else begin s = 2'b00; l = -(r + h); end
    e = clamp18(xv - l);
    l = clamp18(l);
  endtask

  task automatic mreset(input int d);
    ph[d] = 0; cnt[d] = 0; pend[d] = 0; e_sv[d] = 0; e_bv[d] = 0; e_sym[d] = 0;
    px[d] = 0; rr[d] = 32768; sa[d] = 0; se[d] = 0; e_slc[d] = 0; e_err[d] = 0; e_x[d] = 0; e_pow[d] = 0;
  endtask

  task automatic mstep(input int d);
    longint r0 = rr[d];
    longint a, l, e;
    logic [1:0] s;
    int cp;
    e_bv[d] = 0;
    if (e_sv[d]) begin
      a = (e_x[d] == -131072) ? 131071 : (e_x[d] < 0 ? -e_x[d] : e_x[d]);
      sa[d] += a;
      se[d] += e_err[d] * e_err[d];
      cnt[d]++;
      if (cnt[d] == 256) begin
        rr[d] = (sa[d] / 256 < 1) ? 1 : sa[d] / 256;
        e_pow[d] = se[d] / 256;
        e_bv[d] = 1;
        sa[d] = 0; se[d] = 0; cnt[d] = 0;
      end
    end
    e_sv[d] = pend[d];
    if (pend[d]) begin
      slice(px[d], r0, s, l, e);
      e_sym[d] = s; e_slc[d] = l; e_err[d] = e; e_x[d] = px[d];
    end
    pend[d] = 0;
    if (sam) begin
      cp = sym ? 0 : ph[d];
      if (cp == (d == 0 ? 0 : 2)) begin pend[d] = 1; px[d] = sig; end
      ph[d] = (cp + 1) % 4;
    end
  endtask

  function automatic logic [93:0] exp_vec(input int d);
    return {e_sym[d], e_sv[d], 18'(e_slc[d]), 18'(e_err[d]), 18'(rr[d]), 36'(e_pow[d]), e_bv[d]};
  endfunction

  task automatic cmp_vec(input string nm, input logic [93:0] a, input logic [93:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic chk(input string nm, input longint a, input longint e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin mreset(0); mreset(1); end
    else begin mstep(0); mstep(1); end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && reset_n) begin
      cmp_vec("cycle_dut0", {if0.sym_out, if0.sym_valid, if0.slicer_out, if0.err_out, if0.ref_level, if0.err_pow, if0.block_valid}, exp_vec(0));
      cmp_vec("cycle_dut1", {if1.sym_out, if1.sym_valid, if1.slicer_out, if1.err_out, if1.ref_level, if1.err_pow, if1.block_valid}, exp_vec(1));
      if (if0.block_valid) bv_cnt++;
    end
  end

  task automatic send_symbol(input int base, input int step, input bit stray, output logic [2:0] h);
    h = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) h[c-1] = if0.sym_valid;
      sam = (c % 4 == 0);
      sym = (c == 0) || (stray && c == 6);
      sig = 18'(base + (c / 4) * step);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ref"}, if0.ref_level, 32768);
    chk({nm, "_sv"}, if0.sym_valid, 0);
    chk({nm, "_slc"}, if0.slicer_out, 0);
    chk({nm, "_err"}, if0.err_out, 0);
    chk({nm, "_pow"}, if0.err_pow, 0);
  endtask

  initial begin
    reset_n = 1'b1; sam = 1'b0; sym = 1'b0; sig = '0;
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("rst0");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1; chk_en = 1'b1;
    send_symbol(49152, 0, 1'b0, svh);
    chk("lat_c1", svh[0], 0);
    chk("lat_c2", svh[1], 1);
    chk("lat_c3", svh[2], 0);
    chk("ideal_sym", if0.sym_out, 2);
    chk("ideal_slc", if0.slicer_out, 49152);
    chk("ideal_err", if0.err_out, 0);
    for (int i = 0; i < 6; i++) begin
      send_symbol(int'(tx[i]), 0, 1'b0, svh);
      chk($sformatf("thr%0d_sym", i), if0.sym_out, ts[i]);
      chk($sformatf("thr%0d_err", i), if0.err_out, te[i]);
    end
    send_symbol(1000, 100, 1'b1, svh);
    chk("ph_a_dut1_sym", if1.sym_out, 3);
    chk("ph_a_dut1_err", if1.err_out, -15184);
    chk("ph_a_dut0_err", if0.err_out, -15384);
    send_symbol(-40000, 5000, 1'b1, svh);
    chk("ph_b_dut1_sym", if1.sym_out, 1);
    chk("ph_b_dut1_err", if1.err_out, -13616);
    chk("ph_b_dut0_sym", if0.sym_out, 0);
    chk("ph_b_dut0_err", if0.err_out, 9152);
    send_symbol(5000, 30000, 1'b1, svh);
    chk("ph_c_dut1_err", if1.err_out, 15848);
    @(negedge clk); sam = 1'b1; sym = 1'b1; sig = 18'sd20000;
    @(negedge clk); sam = 1'b0; sym = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    b0 = bv_cnt;
    for (int i = 0; i < 256; i++) send_symbol(int'(pat[i % 4]), 0, 1'b0, svh);
    chk("blk1_count", bv_cnt - b0, 1);
    chk("blk1_ref", if0.ref_level, 40000);
    chk("blk1_pow", if0.err_pow, 65377280);
    for (int i = 0; i < 256; i++) send_symbol(int'(pat[i % 4]), 0, 1'b0, svh);
    chk("blk2_count", bv_cnt - b0, 2);
    chk("blk2_ref", if0.ref_level, 40000);
    chk("blk2_pow", if0.err_pow, 0);
    for (int i = 0; i < 100; i++) send_symbol(int'(pat[i % 4]), 0, 1'b0, svh);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 chk("rst_blk_ref", if0.ref_level, 32768);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    b0 = bv_cnt;
    for (int i = 0; i < 255; i++) send_symbol(int'(pat[i % 4]), 0, 1'b0, svh);
    chk("rst_blk_255", bv_cnt - b0, 0);
    send_symbol(int'(pat[3]), 0, 1'b0, svh);
    chk("rst_blk_256", bv_cnt - b0, 1);
    chk("rst_blk_ref_new", if0.ref_level, 40000);
    @(negedge clk); @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
